mandelbrot_pixel_collector: RTL and testbench

- Consumer side of the Mandelbrot engine's run/running/ctr_out handshake.
- Issues one `run` request per pixel and captures the 4-bit iteration result when the engine stops.
- Packs two pixels per byte and buffers the bytes in a small FIFO.
- Streams the bytes out over a valid/ready interface with end-of-line and end-of-frame tags, toward the display/SPI output logic.

---
 rtl/mandelbrot_pixel_collector.sv | 168 ++++++++++++++++
 tb/tb_mandelbrot_pixel_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_pixel_collector.sv
// Consumer for the Mandelbrot engine: issues one run per pixel and packs two 4-bit results per byte into a FWFT FIFO.
// Build option MANDEL_COLLECT_HEADER_EN: push a 0xA5 header byte at the start of every frame.
module mandelbrot_pixel_collector #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       run,
  input  logic       running,
  input  logic [3:0] ctr_in,
  output logic [7:0] out_data,
  output logic       out_eol,
  output logic       out_eof,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          half_q;
  logic [3:0]    held_q;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic       has_room;
  logic       capture;
  logic       x_last, y_last;
  logic       pix_push, hdr_push, push, pop;
  logic [9:0] push_word;

  assign has_room = (count < FULL_COUNT);
  assign capture  = (state_q == WAIT_DONE) && !running;
  assign x_last   = (x_q == X_LAST);
  assign y_last   = (y_q == Y_LAST);
  assign pix_push = capture && half_q;

`ifdef MANDEL_COLLECT_HEADER_EN
  assign hdr_push = (state_q == HEADER) && has_room;
`else
  assign hdr_push = 1'b0;
`endif

  assign push      = pix_push || hdr_push;
  assign pop       = out_valid && out_ready;
  assign push_word = hdr_push ? {8'hA5, 2'b00}
                              : {held_q, ctr_in, x_last, x_last && y_last};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MANDEL_COLLECT_HEADER_EN
          state_d = HEADER;
`else
          state_d = ISSUE;
`endif
        end
      end
      HEADER:     if (has_room) state_d = ISSUE;
      ISSUE:      if (has_room) state_d = WAIT_START;
      WAIT_START: if (running)  state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!running) state_d = (x_last && y_last) ? DONE : ISSUE;
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    run        = 1'b0;
    case (state_q)
      HEADER, WAIT_START, WAIT_DONE: busy = 1'b1;
      ISSUE: begin
        busy = 1'b1;
        run  = has_room;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Pixel position and half-byte holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      half_q <= 1'b0;
      held_q <= 4'h0;
    end else if (state_q == DONE) begin
      x_q    <= '0;
      y_q    <= '0;
      half_q <= 1'b0;
    end else if (capture) begin
      half_q <= ~half_q;
      if (!half_q) held_q <= ctr_in;
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Output FIFO; ISSUE only proceeds with a free slot, so a push never meets a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign {out_data, out_eol, out_eof} = out_valid ? mem[rd_ptr] : 10'h000;

endmodule

// File: tb/tb_mandelbrot_pixel_collector.sv
// Directed bench for mandelbrot_pixel_collector: engine model, expected-byte queue, immediate assertions.
module tb_mandelbrot_pixel_collector;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;
  localparam int BYTES = W * H / 2;
`ifdef MANDEL_COLLECT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, running, out_ready;
  logic [3:0] ctr_in;
  logic       busy, frame_done, run, out_eol, out_eof, out_valid;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  mandelbrot_pixel_collector #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .run(run), .running(running), .ctr_in(ctr_in), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Engine: running high for 3 cycles after run, result = pixel index mod 16
  logic [1:0] eng_cnt;
  logic [7:0] eng_idx;
  logic       eng_clr;

  always @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      eng_cnt <= 2'd0;
      ctr_in  <= 4'h0;
      eng_idx <= 8'd0;
    end else begin
      if (eng_clr) eng_idx <= 8'd0;
      if (run) begin
        running <= 1'b1;
        eng_cnt <= 2'd3;
        ctr_in  <= eng_idx[3:0];
        eng_idx <= eng_idx + 8'd1;
      end else if (eng_cnt > 2'd1) begin
        eng_cnt <= eng_cnt - 2'd1;
      end else if (eng_cnt == 2'd1) begin
        eng_cnt <= 2'd0;
        running <= 1'b0;
      end
    end
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] exp_q[$];
  int         runs_seen = 0, eol_seen = 0, eof_seen = 0, fd_seen = 0, xfers = 0;
  logic       busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe at the current negedge (inputs already set), then advance one cycle
  task automatic tick();
    logic [9:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      xfers++;
      if (out_eol === 1'b1) eol_seen++;
      if (out_eof === 1'b1) eof_seen++;
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_byte observed=%0h expected=none", {out_data, out_eol, out_eof});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte{data,eol,eof}", {22'd0, out_data, out_eol, out_eof}, {22'd0, e});
      end
    end
    if (run === 1'b1) runs_seen++;
    if (frame_done === 1'b1) begin
      fd_seen++;
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("busy_before_done", {31'd0, busy_prev}, 32'd1);
    end
    busy_prev = busy;
    @(negedge clk);
  endtask

  task automatic push_expected();
    int p0, p1;
    logic [3:0] n0, n1;
    if (HDR != 0) exp_q.push_back({8'hA5, 2'b00});
    for (int k = 0; k < BYTES; k++) begin
      p0 = 2 * k;
      p1 = 2 * k + 1;
      n0 = p0[3:0];
      n1 = p1[3:0];
      exp_q.push_back({n0, n1, (p1 % W) == W - 1, p1 == W * H - 1});
    end
  endtask

  task automatic new_frame();
    eng_clr = 1'b1;
    tick();
    eng_clr = 1'b0;
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for frame_done, drain the expected queue, confirm a single pulse
  task automatic finish_frame(input string tag, input int fd0, input bit toggle);
    int n;
    n = 0;
    while (fd_seen == fd0 && n < 2000) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    chk({tag, "_frame_done_seen"}, {31'd0, fd_seen != fd0}, 32'd1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    out_ready = 1'b1;
    repeat (5) tick();
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_frame_done_count"}, fd_seen - fd0, 32'd1);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int r0, fd0, n;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; eng_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {22'd0, busy, frame_done, run, out_valid, out_data, out_eol, out_eof},
        32'd0);

    // Free-flowing frame
    out_ready = 1'b1;
    fd0 = fd_seen;
    new_frame();
    finish_frame("basic", fd0, 1'b0);

    // Backpressure: FIFO fills, run stops, then resumes
    out_ready = 1'b0;
    fd0 = fd_seen;
    r0 = runs_seen;
    new_frame();
    repeat (150) tick();
    chk("bp_runs_issued", runs_seen - r0, 2 * (D - HDR));
    chk("bp_run_held", {31'd0, run}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_nothing_popped", exp_q.size(), BYTES + HDR);
    out_ready = 1'b1;
    finish_frame("bp", fd0, 1'b0);

    // Extra start mid-frame is ignored
    fd0 = fd_seen;
    new_frame();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("restart", fd0, 1'b0);

    // Reset while waiting for the third pixel, then a clean frame
    r0 = runs_seen;
    new_frame();
    n = 0;
    while (!((runs_seen - r0) >= 3 && running === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_wait_done", {31'd0, running === 1'b1}, 32'd1);
    tick();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("post_reset_run", {31'd0, run}, 32'd0);
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    repeat (10) tick();
    fd0 = fd_seen;
    new_frame();
    finish_frame("after_reset", fd0, 1'b0);

    // out_ready toggling every cycle
    fd0 = fd_seen;
    xfers = 0; eol_seen = 0; eof_seen = 0;
    new_frame();
    finish_frame("toggle", fd0, 1'b1);
    chk("toggle_bytes", xfers, BYTES + HDR);
    chk("toggle_eol_count", eol_seen, H);
    chk("toggle_eof_count", eof_seen, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
